// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: fetches instruction words over an imem req/ack
// handshake, presents them to decode over valid/ready, and manages start, halt and fetch timeout.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        running,
    output logic        timeout_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] HALTED = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign running     = (state == FETCH) || (state == ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            wait_cnt    <= 8'h0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc       <= RESET_PC;
                        wait_cnt <= 8'h0;
                        state    <= FETCH;
                    end
                end
                // A redirect outranks an ack arriving in the same cycle, so that word is discarded.
                FETCH: begin
                    if (redirect) begin
                        pc       <= redirect_target;
                        wait_cnt <= 8'h0;
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        instr_pc <= pc;
                        wait_cnt <= 8'h0;
                        state    <= ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        if (halt) begin
                            state <= HALTED;
                        end else if (redirect) begin
                            pc    <= redirect_target;
                            state <= FETCH;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= FETCH;
                        end
                    end else if (redirect) begin
                        pc    <= redirect_target;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (start) begin
                        pc       <= RESET_PC;
                        wait_cnt <= 8'h0;
                        state    <= FETCH;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: expected fetch addresses and issued words are queued
// up front and a monitor pops them as the DUTs present requests and handshakes.
module tb_pc_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance a: default parameters, full control/data path tests
    logic        reset, start, imem_ack, instr_ready, redirect, halt, ack_en;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid, running, timeout_err;
    logic [31:0] imem_addr, instr, instr_pc, pc;

    // Instance b: high reset PC for wraparound, short timeout
    logic        b_reset, b_start, b_imem_ack, b_ack_en;
    logic [31:0] b_imem_rdata;
    logic        b_imem_req, b_instr_valid, b_running, b_timeout_err;
    logic [31:0] b_imem_addr, b_instr, b_instr_pc, b_pc;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ipc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] b_exp_addr_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h1111_1111;
            32'h0000_0004: return 32'h2222_2222;
            32'h0000_0008: return 32'hABCD_EF01;
            32'h0000_000C: return 32'h4444_4444;
            32'h0000_0010: return 32'h5555_5555;
            32'h8765_4320: return 32'h6666_6666;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Memory model acknowledges on the first request cycle whenever enabled.
    assign imem_ack     = ack_en & imem_req;
    assign imem_rdata   = mem_word(imem_addr);
    assign b_imem_ack   = b_ack_en & b_imem_req;
    assign b_imem_rdata = mem_word(b_imem_addr);

    pc_fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .pc(pc), .running(running), .timeout_err(timeout_err)
    );

    pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .MAX_WAIT(4)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
        .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
        .pc(b_pc), .running(b_running), .timeout_err(b_timeout_err)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic unexpected(input string name, input logic [31:0] actual);
        n_total++;
        $display("[TB] FAIL %s: unexpected event with value %h, expected none", name, actual);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: inputs settle at the falling edge, so 1 ns later both sides of the next edge are visible.
    always @(negedge clk) begin
        #1;
        if (imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) unexpected("fetch_addr", imem_addr);
            else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (instr_valid && instr_ready) begin
            if (exp_ipc_q.size() == 0) unexpected("issue_pc", instr_pc);
            else begin
                check("issue_pc", instr_pc, exp_ipc_q.pop_front());
                check("issue_instr", instr, exp_instr_q.pop_front());
            end
        end
        if (b_imem_req && b_imem_ack) begin
            if (b_exp_addr_q.size() == 0) unexpected("b_fetch_addr", b_imem_addr);
            else check("b_fetch_addr", b_imem_addr, b_exp_addr_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; instr_ready = 1'b1; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 32'h0; ack_en = 1'b1;
        b_reset = 1'b1; b_start = 1'b0; b_ack_en = 1'b0;

        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h8765_4320, 32'h10, 32'h0};
        exp_ipc_q  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_instr_q = '{32'h1111_1111, 32'h2222_2222, 32'hABCD_EF01, 32'h4444_4444, 32'h5555_5555};
        b_exp_addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC};

        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b0;
        step();
        check("idle_no_req", imem_req, 1'b0);
        start = 1'b1;
        step(); start = 1'b0;
        check("n1_req", imem_req, 1'b1);
        check("n1_valid", instr_valid, 1'b0);
        check("n1_running", running, 1'b1);
        step(); check("n2_valid", instr_valid, 1'b1);
        step(); check("n3_valid", instr_valid, 1'b0);
        step(); check("n4_valid", instr_valid, 1'b1);
        step(); instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_instr", instr, 32'hABCD_EF01);
            check("stall_instr_pc", instr_pc, 32'h8);
            check("stall_valid", instr_valid, 1'b1);
        end
        instr_ready = 1'b1;
        step(); check("after_stall_addr", imem_addr, 32'hC);
        step(); redirect = 1'b1; redirect_pc = 32'h8765_4323;
        step(); redirect_pc = 32'h0000_0013;
        step(); redirect = 1'b0;
        step(); halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step(); halt = 1'b0; redirect = 1'b0;
        check("halt_running", running, 1'b0);
        check("halt_pc", pc, 32'h10);
        check("halt_req", imem_req, 1'b0);
        step();
        check("halt_hold_pc", pc, 32'h10);
        start = 1'b1;
        step(); start = 1'b0;
        check("restart_addr", imem_addr, 32'h0);
        step(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h4;
        step(); redirect = 1'b0; ack_en = 1'b0; instr_ready = 1'b1;
        check("flush_addr", imem_addr, 32'h4);
        check("flush_valid", instr_valid, 1'b0);
        step(); step();
        #3 reset = 1'b1;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        check("async_rst_running", running, 1'b0);
        check("async_rst_pc", pc, 32'h0);

        step();
        check("b_rst_pc", b_pc, 32'hFFFF_FFF8);
        check("b_rst_req", b_imem_req, 1'b0);
        b_reset = 1'b0; b_ack_en = 1'b1;
        step(); b_start = 1'b1;
        step(); b_start = 1'b0;
        step(); step(); step();
        step(); b_ack_en = 1'b0;
        check("b_wrap_addr", b_imem_addr, 32'h0);
        check("b_wrap_req", b_imem_req, 1'b1);
        step(); step();
        step();
        check("b_wait_req", b_imem_req, 1'b1);
        check("b_wait_timeout", b_timeout_err, 1'b0);
        step();
        check("b_err_timeout", b_timeout_err, 1'b1);
        check("b_err_req", b_imem_req, 1'b0);
        check("b_err_running", b_running, 1'b0);
        b_start = 1'b1;
        step(); b_start = 1'b0;
        check("b_err_sticky", b_timeout_err, 1'b1);
        check("b_err_ignores_start", b_imem_req, 1'b0);
        #3 b_reset = 1'b1;
        #1;
        check("b_async_rst_timeout", b_timeout_err, 1'b0);
        check("b_async_rst_pc", b_pc, 32'hFFFF_FFF8);

        step(); step();
        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'h0);
        check("issue_queue_drained", 32'(exp_ipc_q.size()), 32'h0);
        check("b_addr_queue_drained", 32'(b_exp_addr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Sequencing controller for the processor's 32-bit program counter. It holds the PC and fetches instruction words from instruction memory through a req/ack handshake. Each fetched word goes to decode through a valid/ready handshake, and the PC then advances by 4 or takes a redirect (branch/jump) target. It sits between instruction memory and the decode stage of the convolution processor and owns start, halt and fetch-timeout control.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset and on every start.
- MAX_WAIT, 15: cycles FETCH may wait for imem_ack before error (range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin or restart execution from RESET_PC (honoured in IDLE and HALTED only).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= PC).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr  out  32  latched instruction word.
- instr_pc  out  32  address instr was fetched from.
- instr_ready  in  1  decode accepts instr.
- redirect  in  1  load redirect_pc as the next fetch address.
- redirect_pc  in  32  target; bits [1:0] forced to 0 on load.
- halt  in  1  decode flags accepted instr as HALT.
- pc  out  32  current PC register.
- running  out  1  state is FETCH or ISSUE.
- timeout_err  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, ISSUE, HALTED, ERROR. All outputs are registered or decoded from state only (Moore); no input reaches any output in the same cycle.
- Reset (async) values:
  - state = IDLE, pc = RESET_PC.
  - instr = 0, instr_pc = 0, wait count = 0.
  - imem_req, instr_valid, running and timeout_err = 0.
- IDLE: start=1 → pc := RESET_PC; go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. Priority per cycle:
  - redirect=1 → pc := {redirect_pc[31:2],2'b00}; wait := 0; stay in FETCH. Any ack this cycle is discarded.
  - else imem_ack=1 → instr := imem_rdata; instr_pc := pc; wait := 0; go to ISSUE.
  - else wait == MAX_WAIT-1 → timeout_err := 1; go to ERROR.
  - else wait := wait+1.
- ISSUE: instr_valid=1; imem_req=0. Priority per cycle:
  - instr_ready=1 and halt=1 → HALTED. pc is unchanged; redirect is ignored.
  - instr_ready=1 and redirect=1 → pc := aligned redirect_pc; go to FETCH.
  - instr_ready=1 → pc := pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); go to FETCH.
  - instr_ready=0 and redirect=1 → drop instr (flush); pc := aligned redirect_pc; go to FETCH.
  - otherwise hold. instr and instr_pc stay stable while valid and not ready.
- HALTED: running=0, no requests. start=1 → pc := RESET_PC; go to FETCH.
- ERROR: all requests and valids are 0; timeout_err=1. Only reset exits this state; start is ignored.
- halt is only sampled on the ISSUE handshake cycle. start is ignored in FETCH and ISSUE.

## Timing
- start high at edge N → imem_req=1 and imem_addr=RESET_PC after edge N.
- Ack at edge M → instr_valid=1 after edge M.
- Ready at edge K → imem_req=1 with the new PC after edge K.
- Best-case throughput: one instruction per 2 cycles.
- Timeout: with no ack, ERROR is entered on the MAX_WAIT-th edge spent in FETCH, counted from the first edge in FETCH.
- Asserting reset in any state drops imem_req and instr_valid immediately (asynchronous). The first fetch after reset requires a new start.

## Test plan
- Reset, start, memory acks every request on its first cycle, decode always ready → imem_addr sequence 0,4,8,12; instr_pc matches each address; instr_valid pulses every 2nd cycle.
- Decode holds instr_ready=0 for 3 cycles on the word at 0x8 (data 32'hABCDEF01) → instr and instr_pc stay 32'hABCDEF01 / 0x8 throughout; the next imem_addr is 0xC.
- Redirect with redirect_pc=32'h87654323 on the ISSUE handshake → next imem_addr = 32'h87654320. Repeat the redirect in FETCH at the same cycle as imem_ack → the fetched word is never presented; the refetch goes to the target.
- RESET_PC=32'hFFFF_FFF8, two sequential fetches → addresses FFFF_FFF8, FFFF_FFFC, then 0x0.
- Halt asserted with instr_ready at 0x10, redirect also high → HALTED, running=0, pc stays 0x10. Then start → fetch at RESET_PC.
- MAX_WAIT=4, no ack → ERROR after 4 FETCH edges with timeout_err=1; start is ignored. Reset mid-FETCH clears timeout_err and imem_req asynchronously.
